// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo
// Receives the hps_io keyboard event stream (ps2_key), detects each new
// event by a change of the toggle bit, and queues {pressed, extended, code}
// in a first-word-fall-through FIFO that the CPU drains with a pop strobe.
//
// Optional build macro:
//   PS2_KEY_FIFO_BREAK_FILTER_EN - key-release (break) events are consumed
//   by the toggle tracker but never enqueued and never raise overflow.
//
// All outputs are decoded from registers only; pop and ps2_key have no
// combinational path to any output.

module ps2_key_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4  // FIFO depth is 2**DEPTH_LOG2, legal 2..8
) (
  input  logic                  clk,
  input  logic                  reset,     // synchronous, active-high
  input  logic [10:0]           ps2_key,   // {toggle, pressed, extended, code}
  input  logic                  pop,       // dequeue head entry
  output logic [9:0]            rd_data,   // head entry, 0 while empty
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,  // sticky: an event was dropped
  input  logic                  ovf_clr    // clears overflow
);

  // Count value that means "every slot occupied".
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                  last_tog_q, last_tog_d;
  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2-1:0] rp_q, rp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [9:0]            mem_q [0:(1 << DEPTH_LOG2) - 1];

  // Per-cycle decisions
  logic key_event;   // toggle bit differs from the tracked copy
  logic accept;      // event that is eligible for queuing
  logic fifo_empty;
  logic fifo_full;
  logic do_push;
  logic do_pop;
  logic ovf_set;

  // Decide what happens this cycle: event detection, push, pop, drop.
  always_comb begin
    key_event = ps2_key[10] ^ last_tog_q;
`ifdef PS2_KEY_FIFO_BREAK_FILTER_EN
    // Release events still update the toggle tracker but are discarded here.
    accept    = key_event & ps2_key[9];
`else
    accept    = key_event;
`endif
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    do_pop     = pop & ~fifo_empty;
    // When full, a same-cycle pop frees the head slot so the event still fits.
    do_push    = accept & (~fifo_full | pop);
    ovf_set    = accept & fifo_full & ~pop;
  end

  // Next-state values for pointers, count, overflow and toggle tracker.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    last_tog_d = ps2_key[10];
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins, so the event is not lost.
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Control registers; reset clears pointers, count and overflow.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // The toggle tracker loads ps2_key[10] in reset too, so reset release
    // never looks like a new event.
    last_tog_q <= last_tog_d;
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; written at wp on every accepted push outside reset.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; with count cleared its
    // stale contents are unreachable, and rd_data is forced to 0 when empty.
    if (do_push && !reset) begin
      mem_q[wp_q] <= ps2_key[9:0];
    end
  end

  // Output decode from registered state only.
  always_comb begin
    empty    = fifo_empty;
    full     = fifo_full;
    count    = count_q;
    overflow = ovf_q;
    rd_data  = fifo_empty ? 10'h000 : mem_q[rp_q];
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb_ps2_key_fifo
// Directed bench for ps2_key_fifo at DEPTH_LOG2 = 2 (four entries).
// Inputs change 1 ns after the rising edge and outputs are checked there,
// away from the active edge. Expected values are written out by hand.

module tb_ps2_key_fifo;

  localparam int unsigned DL2 = 2;

  logic           clk;
  logic           reset;
  logic [10:0]    ps2_key;
  logic           pop;
  logic           ovf_clr;
  logic [9:0]     rd_data;
  logic           empty;
  logic           full;
  logic [DL2:0]   count;
  logic           overflow;

  int checks = 0;
  int errors = 0;
  logic tog;

  ps2_key_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .pop      (pop),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leave inputs/sampling 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one event (toggle flip) for one edge with optional strobes.
  task automatic send(input logic [9:0] d, input logic p, input logic c);
    tog     = ~tog;
    ps2_key = {tog, d};
    pop     = p;
    ovf_clr = c;
    tick();
    pop     = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    ps2_key = 11'h400;
    tog     = 1'b1;
    pop     = 1'b0;
    ovf_clr = 1'b0;

    // Reset held for 5 cycles with toggle high; release must not create an event.
    repeat (5) tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_full",  32'(full), 32'd0);
    check("rst_rd",    32'(rd_data), 32'h000);
    reset = 1'b0;
    tick();
    tick();
    check("rel_empty", 32'(empty), 32'd1);
    check("rel_count", 32'(count), 32'd0);

    // Single event {0,1,1,75}: visible the cycle after its edge.
    send(10'h375, 1'b0, 1'b0);
    check("ev1_rd",    32'(rd_data), 32'h375);
    check("ev1_count", 32'(count), 32'd1);
    check("ev1_empty", 32'(empty), 32'd0);
    // Push and pop together when not full: count unchanged, new head.
    send(10'h2AA, 1'b1, 1'b0);
    check("pp_count",  32'(count), 32'd1);
    check("pp_rd",     32'(rd_data), 32'h2AA);
    do_pop();
    check("pop_empty", 32'(empty), 32'd1);
    check("pop_rd",    32'(rd_data), 32'h000);
    check("pop_count", 32'(count), 32'd0);

    // Five events into a four-entry FIFO: fifth is dropped.
    send(10'h301, 1'b0, 1'b0);
    send(10'h102, 1'b0, 1'b0);
    send(10'h203, 1'b0, 1'b0);
    send(10'h004, 1'b0, 1'b0);
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_ovf",   32'(overflow), 32'd0);
    send(10'h3FF, 1'b0, 1'b0);
    check("drop_full",  32'(full), 32'd1);
    check("drop_count", 32'(count), 32'd4);
    check("drop_ovf",   32'(overflow), 32'd1);
    check("drop_head",  32'(rd_data), 32'h301);

    // Full with event and pop together: head advances, count and overflow hold.
    send(10'h155, 1'b1, 1'b0);
    check("fpp_count", 32'(count), 32'd4);
    check("fpp_ovf",   32'(overflow), 32'd1);
    check("fpp_head",  32'(rd_data), 32'h102);

    // Drain: remaining originals in order, then the simultaneous entry.
    do_pop();
    check("drain_2", 32'(rd_data), 32'h203);
    do_pop();
    check("drain_3", 32'(rd_data), 32'h004);
    do_pop();
    check("drain_4", 32'(rd_data), 32'h155);
    check("drain_c", 32'(count), 32'd1);
    do_pop();
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rd",    32'(rd_data), 32'h000);

    // Overflow clear alone, then clear coincident with a new drop.
    do_clr();
    check("clr_alone", 32'(overflow), 32'd0);
    send(10'h0A1, 1'b0, 1'b0);
    send(10'h0A2, 1'b0, 1'b0);
    send(10'h0A3, 1'b0, 1'b0);
    send(10'h0A4, 1'b0, 1'b0);
    check("refill_ovf", 32'(overflow), 32'd0);
    send(10'h0A5, 1'b0, 1'b1);
    check("set_wins",   32'(overflow), 32'd1);
    check("set_count",  32'(count), 32'd4);
    check("set_head",   32'(rd_data), 32'h0A1);
    do_clr();
    check("clr_again",  32'(overflow), 32'd0);
    send(10'h0A6, 1'b0, 1'b0);
    check("reset_ovf",  32'(overflow), 32'd1);

    // Reset mid-operation with a coincident event: everything cleared.
    tog     = ~tog;
    ps2_key = {tog, 10'h3C3};
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    tick();
    check("mid_count", 32'(count), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_ovf",   32'(overflow), 32'd0);
    check("mid_rd",    32'(rd_data), 32'h000);

    // Pop while empty is ignored.
    do_pop();
    check("upop_count", 32'(count), 32'd0);
    check("upop_empty", 32'(empty), 32'd1);

    // Make/break pair for code 1C.
    send(10'h21C, 1'b0, 1'b0);
    send(10'h01C, 1'b0, 1'b0);
`ifdef PS2_KEY_FIFO_BREAK_FILTER_EN
    check("mb_count", 32'(count), 32'd1);
    check("mb_head",  32'(rd_data), 32'h21C);
    do_pop();
    check("mb_empty", 32'(empty), 32'd1);
`else
    check("mb_count", 32'(count), 32'd2);
    check("mb_head",  32'(rd_data), 32'h21C);
    do_pop();
    check("mb_break", 32'(rd_data), 32'h01C);
    check("mb_c1",    32'(count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
